addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_pkg.sv | 5 +
 rtl/add_sub.sv | 21 ++
 rtl/fa.sv | 11 +
 rtl/addsub_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM encoding and operand width for the add/sub arbiter.
package addsub_pkg;
    localparam int OP_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/add_sub.sv
// add_sub: ripple add/sub; subtraction inverts b and injects the +1 as carry-in.
module add_sub import addsub_pkg::*; (
    input  logic [OP_W-1:0] i_a,
    input  logic [OP_W-1:0] i_b,
    input  logic            i_sub,
    output logic [OP_W-1:0] o_sum,
    output logic            o_carry
);
    logic [OP_W:0] w_c;
    assign w_c[0] = i_sub;
    for (genvar g = 0; g < OP_W; g++) begin : g_bit
        fa u_fa (
            .i_a(i_a[g]),
            .i_b(i_b[g] ^ i_sub),
            .i_c(w_c[g]),
            .o_s(o_sum[g]),
            .o_c(w_c[g+1])
        );
    end
    assign o_carry = w_c[OP_W];
endmodule

// File: rtl/fa.sv
// fa: one-bit full adder cell.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one add/sub datapath under round-robin arbitration.
module addsub_arbiter import addsub_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [OP_W-1:0]  req_a0,
    input  logic [OP_W-1:0]  req_b0,
    input  logic [OP_W-1:0]  req_a1,
    input  logic [OP_W-1:0]  req_b1,
    input  logic [1:0]       req_sub,
    output logic [1:0]       req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [OP_W-1:0]  resp_sum,
    output logic             resp_carry,
    output logic             resp_id,
    output logic [CNT_W-1:0] op_count
);
    state_t          r_state, w_next;
    logic            r_last;
    logic [OP_W-1:0] r_a, r_b, w_sum;
    logic            r_sub, r_id, w_carry;
    logic [1:0]      w_grant;
    // r_last holds the most recently granted requester; the other one wins a tie
    always_comb begin
        w_grant = (r_state == IDLE && !rst) ? ((&req_valid) ? (r_last ? 2'b01 : 2'b10) : req_valid) : 2'b00;
        w_next  = (r_state == IDLE) ? ((|req_valid) ? EXEC : IDLE) :
                  (r_state == EXEC) ? HOLD :
                  (r_state == HOLD) ? (resp_ready ? IDLE : HOLD) : IDLE;
    end
    assign req_ready = w_grant;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_carry <= 1'b0;
            resp_id    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (|w_grant) begin
                r_a    <= w_grant[1] ? req_a1 : req_a0;
                r_b    <= w_grant[1] ? req_b1 : req_b0;
                r_sub  <= w_grant[1] ? req_sub[1] : req_sub[0];
                r_id   <= w_grant[1];
                r_last <= w_grant[1];
            end
            if (r_state == EXEC) begin
                resp_valid <= 1'b1;
                resp_sum   <= w_sum;
                resp_carry <= w_carry;
                resp_id    <= r_id;
            end
            if (r_state == HOLD && resp_ready) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end
    add_sub u_add_sub (
        .i_a(r_a),
        .i_b(r_b),
        .i_sub(r_sub),
        .o_sum(w_sum),
        .o_carry(w_carry)
    );
endmodule
